// File: rtl/rr_arb_req_queue_bank_if.sv
`default_nettype none
// ============================================================================
// Module   : rr_arb_req_queue_bank_if
// Purpose  : Push, arbiter and output handshake bundle for the request queue bank.
// Revision : 1.0 - initial release
// ============================================================================
interface rr_arb_req_queue_bank_if #(
    parameter int N_INPUT = 4,
    parameter int DATA_W  = 64
);
    localparam int N_INPUT_WIDTH = $clog2(N_INPUT);

    logic [N_INPUT-1:0]        in_vld_i;
    logic [N_INPUT*DATA_W-1:0] in_data_i;
    logic [N_INPUT-1:0]        in_rdy_o;
    logic [N_INPUT-1:0]        arb_req_o;
    logic [N_INPUT-1:0]        arb_grt_i;
    logic [N_INPUT_WIDTH-1:0]  arb_grt_idx_i;
    logic                      arb_update_o;
    logic                      out_vld_o;
    logic [DATA_W-1:0]         out_data_o;
    logic [N_INPUT_WIDTH-1:0]  out_port_o;
    logic                      out_rdy_i;

    modport slave (
        input  in_vld_i, in_data_i, arb_grt_i, arb_grt_idx_i, out_rdy_i,
        output in_rdy_o, arb_req_o, arb_update_o, out_vld_o, out_data_o, out_port_o
    );

    modport master (
        output in_vld_i, in_data_i, arb_grt_i, arb_grt_idx_i, out_rdy_i,
        input  in_rdy_o, arb_req_o, arb_update_o, out_vld_o, out_data_o, out_port_o
    );
endinterface
`default_nettype wire

// File: rtl/rr_arb_req_queue_bank.sv
`default_nettype none
// ============================================================================
// Module   : rr_arb_req_queue_bank
// Purpose  : Per-port FIFOs feeding a round-robin arbiter; muxes the granted head.
//            Optional macro RR_ARB_REQ_QUEUE_FULL_BYPASS_EN lets a full port push while popping.
// Revision : 1.0 - initial release
// ============================================================================
module rr_arb_req_queue_bank #(
    parameter int N_INPUT = 4,
    parameter int DATA_W  = 64,
    parameter int DEPTH   = 2
) (
    input  wire logic               clk,
    input  wire logic               rst,
    rr_arb_req_queue_bank_if.slave  bus
);
    localparam int N_INPUT_WIDTH = $clog2(N_INPUT);
    localparam int c_PTR_W       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int c_CNT_W       = $clog2(DEPTH + 1);
    localparam logic [c_CNT_W-1:0] c_FULL = c_CNT_W'(DEPTH);
    localparam logic [c_PTR_W-1:0] c_LAST = c_PTR_W'(DEPTH - 1);

    logic [N_INPUT-1:0] w_req;
    logic [N_INPUT-1:0] w_pop;
    logic [N_INPUT-1:0] w_rdy;
    logic [N_INPUT-1:0] w_push;
    logic [DATA_W-1:0]  w_head [N_INPUT];
    logic [DATA_W-1:0]  w_data;
    logic               w_vld;
    logic               w_fire;

    // Explicit wrap keeps non-power-of-two depths correct.
    function automatic logic [c_PTR_W-1:0] f_next(input logic [c_PTR_W-1:0] p);
        return (p == c_LAST) ? '0 : p + 1'b1;
    endfunction

    assign w_vld  = |w_req;
    assign w_fire = w_vld & bus.out_rdy_i;

    for (genvar gi = 0; gi < N_INPUT; gi++) begin : g_port
        logic [c_PTR_W-1:0] r_rd;
        logic [c_PTR_W-1:0] r_wr;
        logic [c_CNT_W-1:0] r_cnt;
        logic [DATA_W-1:0]  r_mem [DEPTH];

        assign w_req[gi] = (r_cnt != '0);
        assign w_pop[gi] = w_fire & bus.arb_grt_i[gi] & w_req[gi];
`ifdef RR_ARB_REQ_QUEUE_FULL_BYPASS_EN
        assign w_rdy[gi] = (r_cnt != c_FULL) | w_pop[gi];
`else
        assign w_rdy[gi] = (r_cnt != c_FULL);
`endif
        assign w_push[gi] = bus.in_vld_i[gi] & w_rdy[gi];
        assign w_head[gi] = r_mem[r_rd];

        always_ff @(posedge clk) begin
            if (rst) begin
                r_rd  <= '0;
                r_wr  <= '0;
                r_cnt <= '0;
            end else begin
                if (w_push[gi]) r_wr <= f_next(r_wr);
                if (w_pop[gi])  r_rd <= f_next(r_rd);
                case ({w_push[gi], w_pop[gi]})
                    2'b10:   r_cnt <= r_cnt + 1'b1;
                    2'b01:   r_cnt <= r_cnt - 1'b1;
                    default: r_cnt <= r_cnt;
                endcase
            end
        end

        // Storage carries no reset; only the occupancy state is cleared.
        always_ff @(posedge clk) begin
            if (w_push[gi]) r_mem[r_wr] <= bus.in_data_i[gi*DATA_W +: DATA_W];
        end
    end

    always_comb begin
        w_data = '0;
        for (int p = 0; p < N_INPUT; p++) begin
            if (bus.arb_grt_idx_i == N_INPUT_WIDTH'(p)) w_data = w_head[p];
        end
    end

    assign bus.in_rdy_o     = w_rdy;
    assign bus.arb_req_o    = w_req;
    assign bus.arb_update_o = w_fire;
    assign bus.out_vld_o    = w_vld;
    assign bus.out_data_o   = w_data;
    assign bus.out_port_o   = w_vld ? bus.arb_grt_idx_i : '0;
endmodule
`default_nettype wire

// File: tb/tb_rr_arb_req_queue_bank.sv
`default_nettype none
// ============================================================================
// Module   : tb_rr_arb_req_queue_bank
// Purpose  : Self-checking bench with a round-robin arbiter model and per-port scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rr_arb_req_queue_bank;
    localparam int N = 4;
    localparam int W = 64;
    localparam int D = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;
    logic [W-1:0] sbq [N][$];
    logic [W-1:0] exp_d;
    logic [1:0]   r_arb_ptr;

    always #5 clk = ~clk;

    rr_arb_req_queue_bank_if #(.N_INPUT(N), .DATA_W(W)) bus ();

    rr_arb_req_queue_bank #(.N_INPUT(N), .DATA_W(W), .DEPTH(D)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Reference round-robin arbiter: priority starts at r_arb_ptr, moves on update.
    always_comb begin
        bus.arb_grt_i     = '0;
        bus.arb_grt_idx_i = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (bus.arb_req_o[(int'(r_arb_ptr) + k) % N]) begin
                bus.arb_grt_i     = '0;
                bus.arb_grt_i[(int'(r_arb_ptr) + k) % N] = 1'b1;
                bus.arb_grt_idx_i = 2'((int'(r_arb_ptr) + k) % N);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst)                   r_arb_ptr <= '0;
        else if (bus.arb_update_o) r_arb_ptr <= bus.arb_grt_idx_i + 2'd1;
    end

    task automatic tick();
        for (int p = 0; p < N; p++) begin
            if (!rst && bus.in_vld_i[p] && bus.in_rdy_o[p]) sbq[p].push_back(bus.in_data_i[p*W +: W]);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.in_vld_i  = '0;
        bus.in_data_i = '0;
        bus.out_rdy_i = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        #1;
        n_cmp++; if (bus.arb_req_o !== 4'b0000) begin n_err++; $display("FAIL reset_req: got %b want 0000", bus.arb_req_o); end
        n_cmp++; if (bus.out_vld_o !== 1'b0) begin n_err++; $display("FAIL reset_vld: got %b want 0", bus.out_vld_o); end
        n_cmp++; if (bus.arb_update_o !== 1'b0) begin n_err++; $display("FAIL reset_upd: got %b want 0", bus.arb_update_o); end
        n_cmp++; if (bus.in_rdy_o !== 4'b1111) begin n_err++; $display("FAIL reset_rdy: got %b want 1111", bus.in_rdy_o); end
        n_cmp++; if (bus.out_port_o !== 2'd0) begin n_err++; $display("FAIL reset_port: got %0d want 0", bus.out_port_o); end
    endtask

    task automatic test_single_push();
        bus.in_vld_i = 4'b0100;
        bus.in_data_i[2*W +: W] = 64'hA;
        bus.out_rdy_i = 1'b1;
        #1;
        n_cmp++; if (bus.arb_req_o !== 4'b0000) begin n_err++; $display("FAIL single_nobypass: got %b want 0000", bus.arb_req_o); end
        tick();
        bus.in_vld_i = '0;
        #1;
        n_cmp++; if (bus.arb_req_o !== 4'b0100) begin n_err++; $display("FAIL single_req: got %b want 0100", bus.arb_req_o); end
        n_cmp++; if (bus.out_port_o !== 2'd2) begin n_err++; $display("FAIL single_port: got %0d want 2", bus.out_port_o); end
        n_cmp++; if (bus.arb_update_o !== 1'b1) begin n_err++; $display("FAIL single_upd: got %b want 1", bus.arb_update_o); end
        n_cmp++;
        if (sbq[2].size() == 0) begin n_err++; $display("FAIL single_sb: got empty scoreboard want 1 entry"); end
        else begin
            exp_d = sbq[2].pop_front();
            if (bus.out_data_o !== exp_d) begin n_err++; $display("FAIL single_data: got %h want %h", bus.out_data_o, exp_d); end
        end
        tick();
        #1;
        n_cmp++; if (bus.arb_req_o !== 4'b0000) begin n_err++; $display("FAIL single_drain: got %b want 0000", bus.arb_req_o); end
    endtask

    task automatic test_round_robin();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.in_vld_i = 4'b1111;
        for (int p = 0; p < N; p++) bus.in_data_i[p*W +: W] = 64'(p);
        bus.out_rdy_i = 1'b1;
        #1;
        tick();
        bus.in_vld_i = '0;
        for (int k = 0; k < N; k++) begin
            #1;
            n_cmp++; if (bus.out_port_o !== 2'(k)) begin n_err++; $display("FAIL rr_port%0d: got %0d want %0d", k, bus.out_port_o, k); end
            n_cmp++; if (bus.arb_update_o !== 1'b1) begin n_err++; $display("FAIL rr_upd%0d: got %b want 1", k, bus.arb_update_o); end
            n_cmp++;
            if (sbq[k].size() == 0) begin n_err++; $display("FAIL rr_sb%0d: got empty scoreboard want 1 entry", k); end
            else begin
                exp_d = sbq[k].pop_front();
                if (bus.out_data_o !== exp_d) begin n_err++; $display("FAIL rr_data%0d: got %h want %h", k, bus.out_data_o, exp_d); end
            end
            tick();
        end
        #1;
        n_cmp++; if (bus.out_vld_o !== 1'b0) begin n_err++; $display("FAIL rr_idle: got %b want 0", bus.out_vld_o); end
    endtask

    task automatic test_full_backpressure();
        logic [W-1:0] beats [3];
        logic exp_rdy;
        logic acc;
        int   n_fire;
        beats[0] = 64'h11; beats[1] = 64'h12; beats[2] = 64'h13;
        bus.out_rdy_i = 1'b0;
        bus.in_vld_i  = 4'b0010;
        for (int b = 0; b < 3; b++) begin
            bus.in_data_i[1*W +: W] = beats[b];
            #1;
            n_cmp++; if (bus.in_rdy_o[1] !== (b < D)) begin n_err++; $display("FAIL full_rdy%0d: got %b want %b", b, bus.in_rdy_o[1], (b < D)); end
            tick();
        end
`ifdef RR_ARB_REQ_QUEUE_FULL_BYPASS_EN
        exp_rdy = 1'b1;
`else
        exp_rdy = 1'b0;
`endif
        bus.out_rdy_i = 1'b1;
        n_fire = 0;
        for (int c = 0; c < 6; c++) begin
            #1;
            if (c == 0) begin
                n_cmp++; if (bus.in_rdy_o[1] !== exp_rdy) begin n_err++; $display("FAIL full_poprdy: got %b want %b", bus.in_rdy_o[1], exp_rdy); end
            end
            if (bus.out_vld_o && bus.out_rdy_i) begin
                n_fire++;
                n_cmp++; if (bus.out_port_o !== 2'd1) begin n_err++; $display("FAIL full_port: got %0d want 1", bus.out_port_o); end
                n_cmp++;
                if (sbq[1].size() == 0) begin n_err++; $display("FAIL full_sb: got empty scoreboard want entry"); end
                else begin
                    exp_d = sbq[1].pop_front();
                    if (bus.out_data_o !== exp_d) begin n_err++; $display("FAIL full_data: got %h want %h", bus.out_data_o, exp_d); end
                end
            end
            acc = bus.in_vld_i[1] & bus.in_rdy_o[1];
            tick();
            if (acc) bus.in_vld_i = '0;
        end
        n_cmp++; if (n_fire !== 3) begin n_err++; $display("FAIL full_nfire: got %0d want 3", n_fire); end
    endtask

    task automatic test_hold();
        bus.out_rdy_i = 1'b0;
        bus.in_vld_i  = 4'b1001;
        bus.in_data_i[0*W +: W] = 64'hB0;
        bus.in_data_i[3*W +: W] = 64'hB3;
        #1;
        tick();
        bus.in_vld_i = '0;
        for (int c = 0; c < 5; c++) begin
            #1;
            n_cmp++; if (bus.out_port_o !== 2'd3) begin n_err++; $display("FAIL hold_port%0d: got %0d want 3", c, bus.out_port_o); end
            n_cmp++; if (bus.out_data_o !== 64'hB3) begin n_err++; $display("FAIL hold_data%0d: got %h want b3", c, bus.out_data_o); end
            n_cmp++; if (bus.arb_update_o !== 1'b0) begin n_err++; $display("FAIL hold_upd%0d: got %b want 0", c, bus.arb_update_o); end
            n_cmp++; if (bus.arb_req_o !== 4'b1001) begin n_err++; $display("FAIL hold_req%0d: got %b want 1001", c, bus.arb_req_o); end
            tick();
        end
        bus.out_rdy_i = 1'b1;
        for (int k = 0; k < 2; k++) begin
            #1;
            n_cmp++; if (bus.out_port_o !== (k == 0 ? 2'd3 : 2'd0)) begin n_err++; $display("FAIL hold_drain_port%0d: got %0d", k, bus.out_port_o); end
            n_cmp++;
            if (sbq[bus.out_port_o].size() == 0) begin n_err++; $display("FAIL hold_sb%0d: got empty scoreboard want entry", k); end
            else begin
                exp_d = sbq[bus.out_port_o].pop_front();
                if (bus.out_data_o !== exp_d) begin n_err++; $display("FAIL hold_drain_data%0d: got %h want %h", k, bus.out_data_o, exp_d); end
            end
            tick();
        end
    endtask

    task automatic test_reset_mid();
        bus.out_rdy_i = 1'b0;
        bus.in_vld_i  = 4'b0011;
        for (int b = 0; b < 2; b++) begin
            bus.in_data_i[0*W +: W] = 64'hC0 + 64'(b);
            bus.in_data_i[1*W +: W] = 64'hD0 + 64'(b);
            #1;
            tick();
        end
        bus.in_vld_i = '0;
        #1;
        n_cmp++; if (bus.in_rdy_o !== 4'b1100) begin n_err++; $display("FAIL mid_full: got %b want 1100", bus.in_rdy_o); end
        rst = 1'b1;
        bus.in_vld_i = 4'b0100;
        bus.in_data_i[2*W +: W] = 64'hEE;
        #1;
        tick();
        rst = 1'b0;
        bus.in_vld_i = '0;
        for (int p = 0; p < N; p++) sbq[p].delete();
        #1;
        n_cmp++; if (bus.arb_req_o !== 4'b0000) begin n_err++; $display("FAIL mid_req: got %b want 0000", bus.arb_req_o); end
        n_cmp++; if (bus.out_vld_o !== 1'b0) begin n_err++; $display("FAIL mid_vld: got %b want 0", bus.out_vld_o); end
        n_cmp++; if (bus.in_rdy_o !== 4'b1111) begin n_err++; $display("FAIL mid_rdy: got %b want 1111", bus.in_rdy_o); end
        tick();
        #1;
        n_cmp++; if (bus.arb_req_o !== 4'b0000) begin n_err++; $display("FAIL mid_dropped: got %b want 0000", bus.arb_req_o); end
    endtask

    initial begin
        test_reset();
        test_single_push();
        test_round_robin();
        test_full_backpressure();
        test_hold();
        test_reset_mid();
        for (int p = 0; p < N; p++) begin
            n_cmp++; if (sbq[p].size() != 0) begin n_err++; $display("FAIL leftover%0d: got %0d want 0", p, sbq[p].size()); end
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
`default_nettype wire
